// File: rtl/keycode_event_queue.sv
// rtl/keycode_event_queue.sv - keycode slot diff into a press/release event FIFO
module keycode_event_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    input  logic       sample_tick,
    output logic [8:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       busy,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       missed_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REL,
        S_PRS,
        S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        latch_cur;
    logic        commit;

    logic [7:0]  cur_q  [4];
    logic [7:0]  prev_q [4];

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic       scan_push;
    logic [8:0] scan_data;
    logic [7:0] sel_key;
    logic       in_other;
    logic       dup_earlier;
    logic       pop;
    logic       full;
    logic       do_write;
    logic       drop;

    assign busy     = (state_q != S_IDLE);
    assign ev_valid = (count_q != '0);
    assign ev_data  = mem_q[rd_ptr_q];
    assign pop      = ev_valid & ev_ready;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_write = scan_push & (~full | pop);
    assign drop     = scan_push & full & ~pop;

    // Scan sequencing: latch on tick, four release steps, four press steps, then commit
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        latch_cur = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    latch_cur = 1'b1;
                    state_d   = S_REL;
                    idx_d     = 2'd0;
                end
            end
            S_REL: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_PRS;
                end
            end
            S_PRS: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Event decision for the current slot: absent from the other set and first of its value in its own set
    always_comb begin
        sel_key     = (state_q == S_PRS) ? cur_q[idx_q] : prev_q[idx_q];
        in_other    = 1'b0;
        dup_earlier = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (state_q == S_PRS) begin
                if (prev_q[j] == sel_key) in_other = 1'b1;
                if ((2'(j) < idx_q) && (cur_q[j] == sel_key)) dup_earlier = 1'b1;
            end else begin
                if (cur_q[j] == sel_key) in_other = 1'b1;
                if ((2'(j) < idx_q) && (prev_q[j] == sel_key)) dup_earlier = 1'b1;
            end
        end
        scan_push = ((state_q == S_REL) || (state_q == S_PRS)) &&
                    (sel_key != 8'h00) && !in_other && !dup_earlier;
        scan_data = {(state_q == S_PRS), sel_key};
    end

    // FSM state, slot index and the current/previous key-set registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cur_q[i]  <= 8'h00;
                prev_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch_cur) begin
                cur_q[0] <= keycode0;
                cur_q[1] <= keycode1;
                cur_q[2] <= keycode2;
                cur_q[3] <= keycode3;
            end
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    prev_q[i] <= cur_q[i];
                end
            end
        end
    end

    // Event FIFO; a push while full is only accepted if the head leaves in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= scan_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_write, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky status flags; a fresh drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            missed_tick <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (sample_tick && busy) begin
                missed_tick <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keycode_event_queue.sv
// tb/tb_keycode_event_queue.sv - randomized and directed check of keycode_event_queue against a set-based model
module tb_keycode_event_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] k [4];
    logic       sample_tick;
    logic [8:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       busy;
    logic       overflow;
    logic       ovf_clr;
    logic       missed_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] m_prev [4];
    logic [7:0] m_cur  [4];
    logic [8:0] m_q [$];
    logic [8:0] m_ev  [8];
    bit         m_evv [8];
    bit         m_busy;
    int         m_pos;
    bit         m_ovf;
    bit         m_missed;

    logic [7:0] pool [6];

    always #5 clk = ~clk;

    keycode_event_queue #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .keycode0    (k[0]),
        .keycode1    (k[1]),
        .keycode2    (k[2]),
        .keycode3    (k[3]),
        .sample_tick (sample_tick),
        .ev_data     (ev_data),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .busy        (busy),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .missed_tick (missed_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_set(input logic [7:0] v, input logic [7:0] s [4], input int upto);
        for (int j = 0; j < upto; j++) begin
            if (s[j] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Releases are prev keys gone from cur, presses are cur keys new vs prev; first occurrence only, slot order
    task automatic model_scan();
        for (int i = 0; i < 8; i++) begin
            m_evv[i] = 1'b0;
            m_ev[i]  = 9'h000;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_prev[i] != 8'h00 && !in_set(m_prev[i], m_cur, 4) && !in_set(m_prev[i], m_prev, i)) begin
                m_evv[i] = 1'b1;
                m_ev[i]  = {1'b0, m_prev[i]};
            end
            if (m_cur[i] != 8'h00 && !in_set(m_cur[i], m_prev, 4) && !in_set(m_cur[i], m_cur, i)) begin
                m_evv[4+i] = 1'b1;
                m_ev[4+i]  = {1'b1, m_cur[i]};
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = 8'h00;
            m_cur[i]  = 8'h00;
        end
        m_busy   = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
        m_missed = 1'b0;
    endtask

    // One clock: compare outputs against the model, drive inputs, advance model across the rising edge
    task automatic cyc(input logic tk, input logic rd, input logic clr, input logic rst);
        check("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("ev_data", 32'(ev_data), 32'(m_q[0]));
        check("busy", 32'(busy), 32'(m_busy));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("missed_tick", 32'(missed_tick), 32'(m_missed));
        sample_tick = tk;
        ev_ready    = rd;
        ovf_clr     = clr;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            bit full;
            bit pop;
            bit drop;
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && rd;
            drop = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (m_busy && m_pos < 8 && m_evv[m_pos]) begin
                if (full && !pop) drop = 1'b1;
                else m_q.push_back(m_ev[m_pos]);
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (m_busy) begin
                if (tk) m_missed = 1'b1;
                if (m_pos == 8) begin
                    for (int i = 0; i < 4; i++) m_prev[i] = m_cur[i];
                    m_busy = 1'b0;
                end else begin
                    m_pos++;
                end
            end else if (tk) begin
                for (int i = 0; i < 4; i++) m_cur[i] = k[i];
                model_scan();
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        k[0] = a; k[1] = b; k[2] = c; k[3] = d;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) cyc(1'b0, rd, 1'b0, 1'b0);
    endtask

    initial begin
        pool[0] = 8'h00; pool[1] = 8'h04; pool[2] = 8'h05;
        pool[3] = 8'h16; pool[4] = 8'h1A; pool[5] = 8'h07;
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        sample_tick = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0; reset = 1'b1;
        model_reset();
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_ev_data", 32'(ev_data), 32'h0);

        // single press: one 104 event, held until drained
        set_keys(8'h04, 8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b0);
        check("single_press_head", 32'(ev_data), 32'h104);
        idle(3, 1'b1);

        // release before press: prev {04,1A} -> cur {1A,07}
        set_keys(8'h04, 8'h1A, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(11, 1'b1);
        set_keys(8'h1A, 8'h07, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11, 1'b0);
        check("rel_first", 32'(ev_data), 32'h004);
        idle(4, 1'b1);

        // duplicate suppression from an empty previous set
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(11, 1'b1);
        set_keys(8'h16, 8'h16, 8'h16, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(11, 1'b1);

        // overflow: 4 presses, then 8 more events into 4 free slots
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b1);
        set_keys(8'h04, 8'h05, 8'h06, 8'h07);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        set_keys(8'h08, 8'h09, 8'h0A, 8'h0B);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        check("ovf_set", 32'(overflow), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_cleared", 32'(overflow), 32'h0);
        idle(10, 1'b1);

        // missed tick: second tick three cycles into the scan
        set_keys(8'h05, 8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        set_keys(8'h06, 8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b1);
        check("missed_set", 32'(missed_tick), 32'h1);

        // reset during the press phase, then the same keys press again
        set_keys(8'h04, 8'h05, 8'h16, 8'h07);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_valid", 32'(ev_valid), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11, 1'b0);
        idle(6, 1'b1);

        // random traffic: keys change freely, ticks may collide with scans
        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < 4; s++) k[s] = pool[$urandom_range(0, 5)];
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
        end
        idle(20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
